// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side forwarding and ALU operand select.
// Build option: define EX_FWD_EN to enable the MEM/WB forwarding muxes.
module id_ex_operand_stage #(
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [2:0]       id_alu_op,
  input  logic [DW-1:0]    id_rd1,
  input  logic [DW-1:0]    id_rd2,
  input  logic [DW-1:0]    id_imm,
  input  logic [4:0]       id_shamt,
  input  logic             id_alu_src,
  input  logic             id_shift,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_dst,
  input  logic             id_reg_write,
  input  logic             mem_reg_write,
  input  logic [RW-1:0]    mem_dst,
  input  logic [DW-1:0]    mem_result,
  input  logic             wb_reg_write,
  input  logic [RW-1:0]    wb_dst,
  input  logic [DW-1:0]    wb_result,
  output logic             ex_valid,
  output logic [2:0]       ex_alu_op,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [DW-1:0]    ex_store_data,
  output logic [RW-1:0]    ex_dst,
  output logic             ex_reg_write,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic          valid;
    logic [2:0]    op;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [4:0]    shamt;
    logic          alu_src;
    logic          shift;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dst;
    logic          reg_write;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;
  logic nxt_valid;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

  always_comb begin
    d           = '0;
    d.valid     = id_valid;
    d.op        = id_alu_op;
    d.rd1       = id_rd1;
    d.rd2       = id_rd2;
    d.imm       = id_imm;
    d.shamt     = id_shamt;
    d.alu_src   = id_alu_src;
    d.shift     = id_shift;
    d.rs        = id_rs;
    d.rt        = id_rt;
    d.dst       = id_dst;
    d.reg_write = id_reg_write & id_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

  // valid as it will be after this edge; low means a bubble cycle
  always_comb begin
    nxt_valid = id_valid;
    if (flush) begin
      nxt_valid = 1'b0;
    end else if (stall) begin
      nxt_valid = q.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (!nxt_valid && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef EX_FWD_EN
  // MEM is the younger producer, so it is checked before WB
  always_comb begin
    fwd_rs = q.rd1;
    if (mem_reg_write && mem_dst == q.rs && q.rs != '0) begin
      fwd_rs = mem_result;
    end else if (wb_reg_write && wb_dst == q.rs && q.rs != '0) begin
      fwd_rs = wb_result;
    end
  end

  always_comb begin
    fwd_rt = q.rd2;
    if (mem_reg_write && mem_dst == q.rt && q.rt != '0) begin
      fwd_rt = mem_result;
    end else if (wb_reg_write && wb_dst == q.rt && q.rt != '0) begin
      fwd_rt = wb_result;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_reg_write, mem_dst, mem_result,
                        wb_reg_write, wb_dst, wb_result,
                        q.rs, q.rt};
  assign fwd_rs = q.rd1;
  assign fwd_rt = q.rd2;
`endif

  always_comb begin
    alu_a = fwd_rs;
    alu_b = fwd_rt;
    if (q.shift) begin
      alu_a = fwd_rt;
      alu_b = {{(DW-5){1'b0}}, q.shamt};
    end else if (q.alu_src) begin
      alu_b = q.imm;
    end
  end

  assign ex_valid      = q.valid;
  assign ex_alu_op     = q.op;
  assign ex_store_data = fwd_rt;
  assign ex_dst        = q.dst;
  assign ex_reg_write  = q.reg_write;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register of the pipelined MIPS; sits directly upstream of the ALU.
- Captures decoded ID-stage fields each cycle and supports stall (hold) and flush (bubble).
- Combinationally forwards EX/MEM and MEM/WB results into the registered register-file operands.
- Selects the ALU a/b operands (register, immediate, or shift amount) and drives op/a/b to the ALU.

Parameters:
- DW, 32, datapath width.
- RW, 5, register address width.
- CNT_W, 16, width of the bubble performance counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  hold all stage registers.
- flush  input  1  load a bubble on the next edge.
- id_valid  input  1  ID holds a real instruction.
- id_alu_op  input  3  ALU control code.
- id_rd1  input  DW  register-file rs value.
- id_rd2  input  DW  register-file rt value.
- id_imm  input  DW  sign-extended immediate.
- id_shamt  input  5  shift amount field.
- id_alu_src  input  1  b operand = immediate.
- id_shift  input  1  shift instruction (sll/srl).
- id_rs  input  RW  rs address.
- id_rt  input  RW  rt address.
- id_dst  input  RW  destination register.
- id_reg_write  input  1  instruction writes the register file.
- mem_reg_write  input  1  EX/MEM writes.
- mem_dst  input  RW  EX/MEM destination.
- mem_result  input  DW  EX/MEM result.
- wb_reg_write  input  1  MEM/WB writes.
- wb_dst  input  RW  MEM/WB destination.
- wb_result  input  DW  MEM/WB result.
- ex_valid  output  1  EX holds a real instruction.
- ex_alu_op  output  3  ALU op.
- alu_a  output  DW  ALU a operand.
- alu_b  output  DW  ALU b operand.
- ex_store_data  output  DW  forwarded rt value, for stores.
- ex_dst  output  RW  registered destination.
- ex_reg_write  output  1  registered write enable, gated by valid.
- bubble_cnt  output  CNT_W  bubble cycles since reset, saturating.

Behaviour:
- Edge priority: rst > flush > stall > load.
- Reset (synchronous, active-high): every register clears to 0, so ex_valid=0, ex_alu_op=000, ex_reg_write=0, ex_dst=0 and bubble_cnt=0. alu_a, alu_b and ex_store_data evaluate to 0 because all fields are 0 and register 0 is never forwarded. Reset asserted mid-stall or mid-flush still clears everything.
- Flush: all fields load 0, giving a bubble (valid=0, reg_write=0). flush wins over a simultaneous stall.
- Stall: all fields hold their values.
- Load: fields take the id_* values. Registered reg_write = id_reg_write & id_valid.
- Latency: one cycle from ID inputs to ex_* outputs. Forwarding and operand selection are combinational from the registered fields and the current mem_/wb_ inputs.
- Forwarding for source s (rs or rt) with registered value v:
  - mem_result if mem_reg_write && mem_dst==s && s!=0;
  - else wb_result if wb_reg_write && wb_dst==s && s!=0;
  - else v.
  - MEM has priority over WB when both match.
- Operand select:
  - shift=1: alu_a = fwd_rt, alu_b = {27'b0, shamt}.
  - shift=0: alu_a = fwd_rs, alu_b = alu_src ? imm : fwd_rt.
  - shift takes precedence over alu_src.
- ex_store_data = fwd_rt always.
- bubble_cnt: increments on each edge where the stage is not in reset and ex_valid==0 after the edge. Concretely: a flush, a load with id_valid=0, or a stall while already invalid. Saturates at 2^CNT_W-1, no wrap.

Optional Feature:
- Macro EX_FWD_EN.
- Defined: forwarding muxes are present as described above.
- Undefined: fwd_rs and fwd_rt are the registered rd1/rd2 values; mem_/wb_ inputs are ignored. Hazards must then be handled upstream by stalling.

Test Plan:
- rst=1 for 2 edges with id_valid=1, id_rd1=5 applied → all outputs 0, bubble_cnt=0.
- Load add: rs=1 (rd1=10), rt=2 (rd2=20), alu_src=0, op=010 → next cycle ex_valid=1, alu_a=10, alu_b=20, ex_alu_op=010.
- Same add with mem_reg_write=1, mem_dst=1, mem_result=7 and wb_reg_write=1, wb_dst=1, wb_result=9 → alu_a=7 (MEM wins). Repeat with mem_dst=0 and rs=0 → alu_a=0, no forwarding.
- sll: rt=3 (rd2=0x1), shamt=4, shift=1, alu_src=1, imm=0x55 → alu_a=1, alu_b=4. lw: alu_src=1, imm=0xFFFFFFFC → alu_b=0xFFFFFFFC, ex_store_data=rd2.
- stall=1 for 3 cycles with changing id_* → outputs frozen. Then stall=1 and flush=1 together → bubble: ex_valid=0, ex_reg_write=0, bubble_cnt +1.
- CNT_W=4, id_valid=0 for 20 cycles → bubble_cnt stops at 15. Then rst=1 → bubble_cnt=0.
